decoder_2_4_pulse: RTL and testbench



---
 rtl/decoder_2_4_pulse_pkg.sv | 16 +
 rtl/decoder_2_4_pulse_onehot_to_bin.sv | 31 +++
 rtl/decoder_2_4_pulse.sv | 164 ++++++++++++++++
 tb/tb_decoder_2_4_pulse.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_2_4_pulse_pkg.sv
// Shared types and helpers for the pulsed binary-to-one-hot decoder.
//   state_e       : FSM state encoding (IDLE, HOLD, GAP)
//   onehot_width  : one-hot width derived from a code width (2**in_w)
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_e;

  function automatic int unsigned onehot_width(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

endpackage

// File: rtl/decoder_2_4_pulse_onehot_to_bin.sv
// Combinational one-hot to binary converter.
//   onehot_i     : one-hot vector, 2**IN_W bits
//   bin_o_c      : OR of the indices of all set bits (the index when one-hot)
//   single_o_c   : high when exactly one bit of onehot_i is set
module onehot_to_bin
  import dec_pkg::*;
#(
  parameter int unsigned IN_W = 2,
  localparam int unsigned OUT_W = onehot_width(IN_W)
) (
  input  logic [OUT_W-1:0] onehot_i,
  output logic [IN_W-1:0]  bin_o_c,
  output logic             single_o_c
);

  logic [IN_W:0] ones;

  // Index OR plus popcount in one pass over the vector
  always_comb begin
    bin_o_c = '0;
    ones    = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (onehot_i[i]) begin
        bin_o_c = bin_o_c | IN_W'(i);
        ones    = ones + (IN_W+1)'(1);
      end
    end
    single_o_c = (ones == (IN_W+1)'(1));
  end

endmodule

// File: rtl/decoder_2_4_pulse.sv
// Pulsed binary-to-one-hot decoder. Accepts a code over valid/ready, then
// drives line (1 << code) for HOLD_CYCLES cycles followed by GAP_CYCLES
// all-zero cycles before the next accept.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_code is valid
//   in_ready    : block can accept a code (registered, high only in IDLE)
//   in_code     : binary code, IN_W bits
//   out_onehot  : registered one-hot output, zero when idle
//   out_valid   : high while out_onehot is non-zero
//   busy        : high in HOLD or GAP
//   dec_err     : sticky loopback-check error (only with DEC_LOOPBACK_CHECK_EN)
// Optional feature macro: DEC_LOOPBACK_CHECK_EN
module decoder_2_4_pulse
  import dec_pkg::*;
#(
  parameter int unsigned IN_W        = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  localparam int unsigned OUT_W = onehot_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  output logic             busy
`ifdef DEC_LOOPBACK_CHECK_EN
  ,
  output logic             dec_err
`endif
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_onehot_q, out_onehot_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               accept_c;

  // in_ready_q is low out of reset, so no accept can happen on the first edge
  assign accept_c = (state_q == IDLE) && in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_onehot_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_onehot_q <= out_onehot_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_onehot_d = out_onehot_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    in_ready_d   = in_ready_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          state_d      = HOLD;
          cnt_d        = CNT_W'(HOLD_CYCLES - 1);
          out_onehot_d = OUT_W'(1) << in_code;
          out_valid_d  = 1'b1;
          busy_d       = 1'b1;
          in_ready_d   = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          out_onehot_d = '0;
          out_valid_d  = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        cnt_d        = '0;
        out_onehot_d = '0;
        out_valid_d  = 1'b0;
        busy_d       = 1'b0;
        in_ready_d   = 1'b0;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_onehot = out_onehot_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

`ifdef DEC_LOOPBACK_CHECK_EN
  logic [IN_W-1:0] code_q;
  logic            dec_err_q, dec_err_d;
  logic [IN_W-1:0] reenc_c;
  logic            single_c;

  onehot_to_bin #(.IN_W(IN_W)) u_onehot_to_bin (
    .onehot_i   (out_onehot_q),
    .bin_o_c    (reenc_c),
    .single_o_c (single_c)
  );

  // Sticky flag: bad re-encode while valid, or any line high while not valid
  always_comb begin
    dec_err_d = dec_err_q;
    if (out_valid_q) begin
      if ((reenc_c != code_q) || !single_c) dec_err_d = 1'b1;
    end else if (out_onehot_q != '0) begin
      dec_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      dec_err_q <= 1'b0;
    end else begin
      if (accept_c) code_q <= in_code;
      dec_err_q <= dec_err_d;
    end
  end

  assign dec_err = dec_err_q;
`endif

endmodule

// File: tb/tb_decoder_2_4_pulse.sv
// Bench for decoder_2_4_pulse: default DUT (IN_W=2,H=4,G=1) and a second DUT
// (IN_W=3,H=1,G=0), both checked every cycle against an age-based model.
module tb_decoder_2_4_pulse;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0;
  logic [1:0] c0 = '0;
  logic       r0, ov0, b0;
  logic [3:0] oh0;

  logic       v1 = 1'b0;
  logic [2:0] c1 = '0;
  logic       r1, ov1, b1;
  logic [7:0] oh1;
`ifdef DEC_LOOPBACK_CHECK_EN
  logic       err0, err1;
`endif

  decoder_2_4_pulse dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_code(c0),
    .out_onehot(oh0), .out_valid(ov0), .busy(b0)
`ifdef DEC_LOOPBACK_CHECK_EN
    , .dec_err(err0)
`endif
  );

  decoder_2_4_pulse #(.IN_W(3), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_code(c1),
    .out_onehot(oh1), .out_valid(ov1), .busy(b1)
`ifdef DEC_LOOPBACK_CHECK_EN
    , .dec_err(err1)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;
  bit chk1_en = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: age = cycles since accept (0 = idle); line high for ages 1..H,
  // busy for ages 1..H+G, ready whenever idle after the first post-reset edge.
  int  hh[2] = '{4, 1};
  int  gg[2] = '{1, 0};
  int  m_age[2];
  int  m_code[2];
  bit  m_ready[2];
  bit  m_acc[2];

  always @(posedge clk or negedge rst_n) begin : model
    logic vin;
    int   cin;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_age[k]   <= 0;
        m_ready[k] <= 1'b0;
        m_acc[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        vin = (k == 0) ? v0 : v1;
        cin = (k == 0) ? int'(c0) : int'(c1);
        m_acc[k] <= 1'b0;
        if (m_age[k] != 0) begin
          m_age[k]   <= (m_age[k] == hh[k] + gg[k]) ? 0 : m_age[k] + 1;
          m_ready[k] <= (m_age[k] == hh[k] + gg[k]);
        end else if (m_ready[k] && vin) begin
          m_age[k]   <= 1;
          m_code[k]  <= cin;
          m_acc[k]   <= 1'b1;
          m_ready[k] <= 1'b0;
        end else begin
          m_ready[k] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_oh(input int k);
    if (m_age[k] >= 1 && m_age[k] <= hh[k]) return 32'(1) << m_code[k];
    return 32'd0;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot0", 32'(oh0), exp_oh(0));
      chk("valid0",  32'(ov0), 32'(exp_oh(0) != 0));
      chk("busy0",   32'(b0),  32'(m_age[0] != 0));
      chk("ready0",  32'(r0),  32'(m_ready[0]));
`ifdef DEC_LOOPBACK_CHECK_EN
      chk("dec_err0", 32'(err0), 32'd0);
`endif
      if (chk1_en) begin
        chk("onehot1", 32'(oh1), exp_oh(1));
        chk("valid1",  32'(ov1), 32'(exp_oh(1) != 0));
        chk("busy1",   32'(b1),  32'(m_age[1] != 0));
        chk("ready1",  32'(r1),  32'(m_ready[1]));
`ifdef DEC_LOOPBACK_CHECK_EN
        chk("dec_err1", 32'(err1), 32'd0);
`endif
      end
    end
  end

  // Present a code on DUT0 until the model sees it accepted; returns #1 after that edge
  task automatic send0(input logic [1:0] code);
    bit got;
    got = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    c0 = code;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = m_acc[0];
    end
    v0 = 1'b0;
    if (!got) chk("accept0_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int n_oh, n_nr;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_onehot", 32'(oh0), 32'd0);
    chk("rst_valid",  32'(ov0), 32'd0);
    chk("rst_busy",   32'(b0),  32'd0);
    chk("rst_ready",  32'(r0),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(r0), 32'd1);

    // Full sweep: 4 hold cycles, 1 gap cycle, then ready
    for (int i = 0; i < 4; i++) begin
      send0(2'(i));
      for (int j = 1; j <= 6; j++) begin
        @(negedge clk);
        chk("sweep_onehot", 32'(oh0), (j <= 4) ? 32'(tbl[i]) : 32'd0);
        chk("sweep_ready",  32'(r0),  (j == 6) ? 32'd1 : 32'd0);
      end
    end

    // Back-to-back with in_valid held: one accept per 6 cycles
    v0 = 1'b1;
    c0 = 2'b10;
    n_oh = 0;
    n_nr = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (oh0 == 4'b0100) n_oh++;
      if (!r0) n_nr++;
    end
    chk("b2b_onehot_cycles", 32'(n_oh), 32'd12);
    chk("b2b_notready_cycles", 32'(n_nr), 32'd15);

    // Code change during hold is ignored
    c0 = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) c0 = 2'b11;
      if (j == 6) v0 = 1'b0;
      chk("hold_stable", 32'(oh0), (j <= 4) ? 32'h2 : 32'd0);
    end

    // Asynchronous reset in the middle of a hold
    send0(2'b11);
    @(posedge clk); #1;
    chk("pre_reset_onehot", 32'(oh0), 32'h8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_onehot", 32'(oh0), 32'd0);
    chk("async_busy",   32'(b0),  32'd0);
    chk("async_valid",  32'(ov0), 32'd0);
    chk("async_ready",  32'(r0),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send0(2'b00);
    @(negedge clk);
    chk("post_reset_onehot", 32'(oh0), 32'h1);
    repeat (6) @(negedge clk);

    // Second DUT: 8 codes, 1-cycle pulse, accept every 2 cycles
    v1 = 1'b1;
    c1 = 3'd0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n % 2 == 1) begin
        chk("w3_onehot", 32'(oh1), 32'(1) << ((n - 1) / 2));
        c1 = 3'((n + 1) / 2);
        if (n == 15) v1 = 1'b0;
      end else begin
        chk("w3_gap", 32'(oh1), 32'd0);
      end
    end

`ifdef DEC_LOOPBACK_CHECK_EN
    chk("dec_err1_clean", 32'(err1), 32'd0);
    chk1_en = 1'b0;
    @(negedge clk);
    force dut1.out_onehot_q = 8'h10;
    @(posedge clk); #1;
    release dut1.out_onehot_q;
    @(negedge clk);
    chk("dec_err1_set", 32'(err1), 32'd1);
    repeat (2) @(negedge clk);
    chk("dec_err1_sticky", 32'(err1), 32'd1);
    chk("dec_err0_clean", 32'(err0), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
